// File: rtl/cipu_seq_pkg.sv
// Shared types and constants for the CIPU sequencer: FSM state encodings,
// stream control characters and load-target selectors.
package cipu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KICK,
    ST_RUN,
    ST_FIN
  } mainState_t;

  typedef enum logic [1:0] {
    T_SEND,
    T_HOLD,
    T_END
  } thingState_t;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_SEMI   = 8'h3B;
  localparam logic [7:0] CH_NUL    = 8'h00;

  localparam logic [1:0] LD_PEOPLE = 2'd0;
  localparam logic [1:0] LD_THING  = 2'd1;
  localparam logic [1:0] LD_NUM    = 2'd2;

  localparam logic [4:0] CNT_MAX = 5'd31;

endpackage

// File: rtl/cipu_seq_if.sv
// Host-load and CIPU-handshake bundle; slave is the sequencer, master is
// whoever drives loads and plays the CIPU.
interface cipu_seq_if;
  logic       ld_en;
  logic [1:0] ld_sel;
  logic [7:0] ld_data;
  logic       start;
  logic       busy;
  logic       done;
  logic       err_timeout;
  logic [4:0] fifo_cnt;
  logic [4:0] lifo_cnt;
  logic       ready_fifo;
  logic       ready_lifo;
  logic [7:0] people_thing_in;
  logic [7:0] thing_in;
  logic [3:0] thing_num;
  logic       valid_fifo;
  logic       valid_lifo;
  logic       done_thing;
  logic       done_fifo;
  logic       done_lifo;

  modport slave (
    input  ld_en, ld_sel, ld_data, start,
    input  valid_fifo, valid_lifo, done_thing, done_fifo, done_lifo,
    output busy, done, err_timeout, fifo_cnt, lifo_cnt,
    output ready_fifo, ready_lifo, people_thing_in, thing_in, thing_num
  );

  modport master (
    output ld_en, ld_sel, ld_data, start,
    output valid_fifo, valid_lifo, done_thing, done_fifo, done_lifo,
    input  busy, done, err_timeout, fifo_cnt, lifo_cnt,
    input  ready_fifo, ready_lifo, people_thing_in, thing_in, thing_num
  );
endinterface

// File: rtl/cipu_seq_thing.sv
// Thing-stream generator: thing buffer, pop-count queue and the
// SEND/HOLD/END sub-FSM that pauses on ';' until the CIPU acknowledges.
module cipu_seq_thing
  import cipu_seq_pkg::*;
#(
  parameter int CHAR_DEPTH = 32,
  parameter int NUM_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_idle,
  input  logic        i_ldEn,
  input  logic [1:0]  i_ldSel,
  input  logic [7:0]  i_ldData,
  input  logic        i_start,
  input  logic        i_step,
  input  logic        i_flush,
  input  logic        i_wpClear,
  input  logic        i_doneThing,
  output thingState_t o_state,
  output logic [7:0]  o_thingIn,
  output logic [3:0]  o_thingNum,
  output logic        o_empty
);
  localparam int AW  = $clog2(CHAR_DEPTH);
  localparam int PW  = $clog2(CHAR_DEPTH + 1);
  localparam int NAW = $clog2(NUM_DEPTH);
  localparam int NW  = $clog2(NUM_DEPTH + 1);

  logic [7:0]    r_thingMem [CHAR_DEPTH];
  logic [3:0]    r_numMem   [NUM_DEPTH];
  logic [PW-1:0] r_thingWp, r_thingRp;
  logic [NW-1:0] r_numWp, r_numRp;
  thingState_t   r_state;
  logic [7:0]    r_thing;
  logic [3:0]    r_num;

  logic       w_ldThing, w_ldNum, w_thingAvail, w_numAvail;
  logic [7:0] w_thingNext;
  logic [3:0] w_numCur;

  assign w_ldThing    = i_idle && i_ldEn && (i_ldSel == LD_THING) && (r_thingWp != PW'(CHAR_DEPTH));
  assign w_ldNum      = i_idle && i_ldEn && (i_ldSel == LD_NUM) && (r_numWp != NW'(NUM_DEPTH));
  assign w_thingAvail = r_thingRp < r_thingWp;
  assign w_numAvail   = r_numRp < r_numWp;
  // An exhausted thing buffer yields a single injected '$' to close the stream.
  assign w_thingNext  = w_thingAvail ? r_thingMem[r_thingRp[AW-1:0]] : CH_DOLLAR;
  assign w_numCur     = w_numAvail ? r_numMem[r_numRp[NAW-1:0]] : 4'd0;

  assign o_state    = r_state;
  assign o_thingIn  = r_thing;
  assign o_thingNum = r_num;
  assign o_empty    = (r_thingWp == '0);

  always_ff @(posedge clk) begin
    if (w_ldThing) r_thingMem[r_thingWp[AW-1:0]] <= i_ldData;
    if (w_ldNum)   r_numMem[r_numWp[NAW-1:0]]    <= i_ldData[3:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= T_SEND;
      r_thing   <= CH_NUL;
      r_num     <= 4'd0;
      r_thingWp <= '0;
      r_thingRp <= '0;
      r_numWp   <= '0;
      r_numRp   <= '0;
    end else begin
      if (w_ldThing) r_thingWp <= r_thingWp + PW'(1);
      if (w_ldNum)   r_numWp   <= r_numWp + NW'(1);
      if (i_wpClear) begin
        r_thingWp <= '0;
        r_numWp   <= '0;
      end
      if (i_start) begin
        r_state   <= T_SEND;
        r_thing   <= CH_NUL;
        r_num     <= 4'd0;
        r_thingRp <= '0;
        r_numRp   <= '0;
      end else if (i_flush) begin
        r_thing <= CH_NUL;
        r_num   <= 4'd0;
      end else if (i_step) begin
        case (r_state)
          T_SEND: begin
            if (r_thing == CH_SEMI) begin
              r_state <= T_HOLD;
              r_thing <= CH_NUL;
              r_num   <= w_numCur;
            end else if (r_thing == CH_DOLLAR) begin
              r_state <= T_END;
              r_thing <= CH_NUL;
            end else begin
              r_thing <= w_thingNext;
              if (w_thingAvail) r_thingRp <= r_thingRp + PW'(1);
            end
          end
          T_HOLD: begin
            if (i_doneThing) begin
              r_state <= T_SEND;
              r_num   <= 4'd0;
              r_thing <= w_thingNext;
              if (w_thingAvail) r_thingRp <= r_thingRp + PW'(1);
              if (w_numAvail)   r_numRp   <= r_numRp + NW'(1);
            end
          end
          T_END:   r_thing <= CH_NUL;
          default: r_state <= T_SEND;
        endcase
      end
    end
  end

endmodule

// File: rtl/cipu_seq.sv
// CIPU sequencer top: people buffer, main IDLE/KICK/RUN/FIN FSM, result
// counters and the handshake watchdog; the thing stream lives in cipu_seq_thing.
module cipu_seq
  import cipu_seq_pkg::*;
#(
  parameter int CHAR_DEPTH = 32,
  parameter int NUM_DEPTH  = 8,
  parameter int TIMEOUT    = 255
) (
  input logic       clk,
  input logic       rst,
  cipu_seq_if.slave bus
);
  localparam int AW = $clog2(CHAR_DEPTH);
  localparam int PW = $clog2(CHAR_DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  mainState_t    r_state;
  logic [7:0]    r_peopleMem [CHAR_DEPTH];
  logic [PW-1:0] r_peopleWp, r_peopleRp;
  logic [7:0]    r_people;
  logic          r_peopleEnd;
  logic          r_busy, r_done, r_errTimeout, r_readyFifo, r_readyLifo;
  logic          r_doneFifo, r_doneLifo;
  logic [4:0]    r_fifoCnt, r_lifoCnt;
  logic [WW-1:0] r_waitCnt;

  thingState_t w_thingState;
  logic        w_idle, w_ldPeople, w_startOk, w_thingEmpty;
  logic        w_bothDone, w_waiting, w_timeoutHit, w_finNow, w_step;
  logic [7:0]  w_peopleNext, w_thingIn;
  logic [3:0]  w_thingNum;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_ldPeople   = w_idle && bus.ld_en && (bus.ld_sel == LD_PEOPLE) && (r_peopleWp != PW'(CHAR_DEPTH));
  assign w_startOk    = w_idle && bus.start && !bus.ld_en && (r_peopleWp != '0) && !w_thingEmpty;
  assign w_bothDone   = r_doneFifo && r_doneLifo;
  // The watchdog covers both a stalled ';' handshake and a CIPU that never reports done.
  assign w_waiting    = (w_thingState == T_HOLD) || (r_peopleEnd && (w_thingState == T_END));
  assign w_timeoutHit = w_waiting && (r_waitCnt == WW'(TIMEOUT - 1));
  assign w_finNow     = (r_state == ST_RUN) && (w_bothDone || w_timeoutHit);
  assign w_step       = (r_state == ST_KICK) || ((r_state == ST_RUN) && !w_finNow);
  assign w_peopleNext = (r_peopleRp < r_peopleWp) ? r_peopleMem[r_peopleRp[AW-1:0]] : CH_DOLLAR;

  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.err_timeout     = r_errTimeout;
  assign bus.fifo_cnt        = r_fifoCnt;
  assign bus.lifo_cnt        = r_lifoCnt;
  assign bus.ready_fifo      = r_readyFifo;
  assign bus.ready_lifo      = r_readyLifo;
  assign bus.people_thing_in = r_people;
  assign bus.thing_in        = w_thingIn;
  assign bus.thing_num       = w_thingNum;

  cipu_seq_thing #(
    .CHAR_DEPTH(CHAR_DEPTH),
    .NUM_DEPTH (NUM_DEPTH)
  ) u_thing (
    .clk        (clk),
    .rst        (rst),
    .i_idle     (w_idle),
    .i_ldEn     (bus.ld_en),
    .i_ldSel    (bus.ld_sel),
    .i_ldData   (bus.ld_data),
    .i_start    (w_startOk),
    .i_step     (w_step),
    .i_flush    (w_finNow),
    .i_wpClear  (r_state == ST_FIN),
    .i_doneThing(bus.done_thing),
    .o_state    (w_thingState),
    .o_thingIn  (w_thingIn),
    .o_thingNum (w_thingNum),
    .o_empty    (w_thingEmpty)
  );

  always_ff @(posedge clk) begin
    if (w_ldPeople) r_peopleMem[r_peopleWp[AW-1:0]] <= bus.ld_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_errTimeout <= 1'b0;
      r_readyFifo  <= 1'b0;
      r_readyLifo  <= 1'b0;
      r_people     <= CH_NUL;
      r_peopleEnd  <= 1'b0;
      r_peopleWp   <= '0;
      r_peopleRp   <= '0;
      r_doneFifo   <= 1'b0;
      r_doneLifo   <= 1'b0;
      r_fifoCnt    <= '0;
      r_lifoCnt    <= '0;
      r_waitCnt    <= '0;
    end else begin
      r_done      <= 1'b0;
      r_readyFifo <= 1'b0;
      r_readyLifo <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ldPeople) r_peopleWp <= r_peopleWp + PW'(1);
          if (w_startOk) begin
            r_state      <= ST_KICK;
            r_busy       <= 1'b1;
            r_readyFifo  <= 1'b1;
            r_readyLifo  <= 1'b1;
            r_errTimeout <= 1'b0;
            r_fifoCnt    <= '0;
            r_lifoCnt    <= '0;
            r_peopleRp   <= '0;
            r_peopleEnd  <= 1'b0;
            r_people     <= CH_NUL;
            r_doneFifo   <= 1'b0;
            r_doneLifo   <= 1'b0;
            r_waitCnt    <= '0;
          end
        end
        ST_KICK, ST_RUN: begin
          if (r_state == ST_RUN) begin
            if (bus.valid_fifo && (r_fifoCnt != CNT_MAX)) r_fifoCnt <= r_fifoCnt + 5'd1;
            if (bus.valid_lifo && (r_lifoCnt != CNT_MAX)) r_lifoCnt <= r_lifoCnt + 5'd1;
            r_doneFifo <= r_doneFifo | bus.done_fifo;
            r_doneLifo <= r_doneLifo | bus.done_lifo;
            r_waitCnt  <= w_waiting ? r_waitCnt + WW'(1) : '0;
          end
          if (w_finNow) begin
            r_state  <= ST_FIN;
            r_done   <= 1'b1;
            r_people <= CH_NUL;
            if (!w_bothDone) r_errTimeout <= 1'b1;
          end else begin
            r_state <= ST_RUN;
            if (r_peopleEnd) begin
              r_people <= CH_NUL;
            end else if (r_people == CH_DOLLAR) begin
              r_people    <= CH_NUL;
              r_peopleEnd <= 1'b1;
            end else begin
              r_people <= w_peopleNext;
              if (r_peopleRp < r_peopleWp) r_peopleRp <= r_peopleRp + PW'(1);
            end
          end
        end
        ST_FIN: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_peopleWp <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cipu_seq.sv
// Directed self-checking bench for cipu_seq; the bench plays both the host
// loader and the CIPU, with hand-computed stream and counter values.
module tb_cipu_seq;
  import cipu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   n;

  cipu_seq_if bus ();

  cipu_seq #(
    .CHAR_DEPTH(32),
    .NUM_DEPTH (8),
    .TIMEOUT   (255)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=hang expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] sel, input logic [7:0] data, input logic st);
    bus.ld_en   = en;
    bus.ld_sel  = sel;
    bus.ld_data = data;
    bus.start   = st;
    tick();
    bus.ld_en   = 1'b0;
    bus.ld_sel  = 2'd0;
    bus.ld_data = 8'h00;
    bus.start   = 1'b0;
  endtask

  task automatic loadStr(input logic [1:0] sel, input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(1'b1, sel, s[i], 1'b0);
  endtask

  task automatic checkStreams(input string tag, input logic [7:0] people, input logic [7:0] thing);
    checkOutput({tag, ".people"}, bus.people_thing_in, people);
    checkOutput({tag, ".thing"}, bus.thing_in, thing);
  endtask

  task automatic waitDone(input int budget, output int cycles);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  task automatic finishRun(input string tag);
    int c;
    bus.done_fifo = 1'b1;
    bus.done_lifo = 1'b1;
    tick();
    bus.done_fifo = 1'b0;
    bus.done_lifo = 1'b0;
    waitDone(10, c);
    checkOutput({tag, ".doneSeen"}, bus.done, 1'b1);
    checkOutput({tag, ".finBusy"}, bus.busy, 1'b1);
    checkOutput({tag, ".noTimeout"}, bus.err_timeout, 1'b0);
    tick();
    checkOutput({tag, ".idleBusy"}, bus.busy, 1'b0);
    checkOutput({tag, ".idleDone"}, bus.done, 1'b0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.ld_en      = 1'b0;
    bus.ld_sel     = 2'd0;
    bus.ld_data    = 8'h00;
    bus.start      = 1'b0;
    bus.valid_fifo = 1'b0;
    bus.valid_lifo = 1'b0;
    bus.done_thing = 1'b0;
    bus.done_fifo  = 1'b0;
    bus.done_lifo  = 1'b0;
    #1 rst = 1'b0;
    #1;
    checkOutput("rst.busy", bus.busy, 1'b0);
    checkOutput("rst.done", bus.done, 1'b0);
    checkOutput("rst.err", bus.err_timeout, 1'b0);
    checkOutput("rst.readyFifo", bus.ready_fifo, 1'b0);
    checkOutput("rst.readyLifo", bus.ready_lifo, 1'b0);
    checkOutput("rst.thingNum", bus.thing_num, 4'd0);
    checkOutput("rst.fifoCnt", bus.fifo_cnt, 5'd0);
    checkStreams("rst", 8'h00, 8'h00);
    tick();
    tick();
    rst = 1'b1;
    tick();

    $display("[TB] start with empty buffers");
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    checkOutput("emptyStart.busy", bus.busy, 1'b0);

    $display("[TB] run A: people AB1C$, things 12;3$, num 2");
    loadStr(LD_PEOPLE, "AB1C$");
    loadStr(LD_THING, "12;3$");
    applyStimulus(1'b1, LD_NUM, 8'hA2, 1'b0);
    applyStimulus(1'b1, 2'd3, 8'h55, 1'b1);
    checkOutput("ldStart.busy", bus.busy, 1'b0);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    checkOutput("A.kick.busy", bus.busy, 1'b1);
    checkOutput("A.kick.readyFifo", bus.ready_fifo, 1'b1);
    checkOutput("A.kick.readyLifo", bus.ready_lifo, 1'b1);
    checkStreams("A.kick", 8'h00, 8'h00);
    tick();
    checkStreams("A.r1", "A", "1");
    checkOutput("A.r1.readyFifo", bus.ready_fifo, 1'b0);
    bus.valid_fifo = 1'b1;
    tick();
    checkStreams("A.r2", "B", "2");
    bus.valid_lifo = 1'b1;
    bus.done_thing = 1'b1;
    tick();
    checkStreams("A.r3", "1", ";");
    bus.done_thing = 1'b0;
    tick();
    checkStreams("A.r4", "C", 8'h00);
    checkOutput("A.r4.thingNum", bus.thing_num, 4'd2);
    bus.valid_lifo = 1'b0;
    tick();
    checkStreams("A.r5", "$", 8'h00);
    checkOutput("A.r5.thingNum", bus.thing_num, 4'd2);
    bus.valid_fifo = 1'b0;
    tick();
    checkStreams("A.r6", 8'h00, 8'h00);
    checkOutput("A.r6.thingNum", bus.thing_num, 4'd2);
    bus.done_thing = 1'b1;
    tick();
    checkStreams("A.r7", 8'h00, "3");
    checkOutput("A.r7.thingNum", bus.thing_num, 4'd0);
    bus.done_thing = 1'b0;
    tick();
    checkOutput("A.r8.thing", bus.thing_in, "$");
    tick();
    checkOutput("A.r9.thing", bus.thing_in, 8'h00);
    checkOutput("A.fifoCnt", bus.fifo_cnt, 5'd4);
    checkOutput("A.lifoCnt", bus.lifo_cnt, 5'd2);
    finishRun("A");

    $display("[TB] run B: things 5;$, num 0");
    loadStr(LD_PEOPLE, "$");
    loadStr(LD_THING, "5;$");
    applyStimulus(1'b1, LD_NUM, 8'hF0, 1'b0);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    checkOutput("B.kick.busy", bus.busy, 1'b1);
    tick();
    checkStreams("B.r1", "$", "5");
    tick();
    checkStreams("B.r2", 8'h00, ";");
    tick();
    checkOutput("B.hold.thing", bus.thing_in, 8'h00);
    checkOutput("B.hold.thingNum", bus.thing_num, 4'd0);
    bus.done_thing = 1'b1;
    tick();
    checkOutput("B.resume.thing", bus.thing_in, "$");
    bus.done_thing = 1'b0;
    tick();
    checkOutput("B.end.thing", bus.thing_in, 8'h00);
    finishRun("B");

    $display("[TB] run C: done_thing never arrives");
    loadStr(LD_PEOPLE, "X$");
    loadStr(LD_THING, ";$");
    applyStimulus(1'b1, LD_NUM, 8'h05, 1'b0);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    tick();
    checkOutput("C.r1.thing", bus.thing_in, ";");
    tick();
    checkOutput("C.hold.thingNum", bus.thing_num, 4'd5);
    checkOutput("C.hold.err", bus.err_timeout, 1'b0);
    waitDone(400, n);
    checkOutput("C.holdCycles", n, 255);
    checkOutput("C.done", bus.done, 1'b1);
    checkOutput("C.err", bus.err_timeout, 1'b1);
    tick();
    checkOutput("C.idleBusy", bus.busy, 1'b0);
    checkOutput("C.idleDone", bus.done, 1'b0);
    checkOutput("C.errSticky", bus.err_timeout, 1'b1);

    $display("[TB] run D: 33 people loads without terminator");
    for (int i = 0; i < 33; i++) applyStimulus(1'b1, LD_PEOPLE, 8'(8'h40 + i), 1'b0);
    loadStr(LD_THING, "$");
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    checkOutput("D.kick.err", bus.err_timeout, 1'b0);
    for (int i = 0; i < 32; i++) begin
      tick();
      checkOutput("D.people", bus.people_thing_in, 8'(8'h40 + i));
    end
    tick();
    checkOutput("D.inject", bus.people_thing_in, "$");
    tick();
    checkOutput("D.after", bus.people_thing_in, 8'h00);
    finishRun("D");

    $display("[TB] run E: reset mid-run");
    loadStr(LD_PEOPLE, "PQ$");
    loadStr(LD_THING, ";$");
    applyStimulus(1'b1, LD_NUM, 8'h09, 1'b0);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    tick();
    bus.valid_fifo = 1'b1;
    tick();
    bus.valid_fifo = 1'b0;
    checkOutput("E.hold.thingNum", bus.thing_num, 4'd9);
    checkOutput("E.fifoCnt", bus.fifo_cnt, 5'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("E.rst.busy", bus.busy, 1'b0);
    checkOutput("E.rst.thingNum", bus.thing_num, 4'd0);
    checkOutput("E.rst.fifoCnt", bus.fifo_cnt, 5'd0);
    checkStreams("E.rst", 8'h00, 8'h00);
    tick();
    rst = 1'b1;
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    checkOutput("E.noReloadStart", bus.busy, 1'b0);
    loadStr(LD_PEOPLE, "PQ$");
    loadStr(LD_THING, "$");
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    checkOutput("E.reload.busy", bus.busy, 1'b1);
    tick();
    checkStreams("E.r1", "P", "$");
    tick();
    checkOutput("E.r2.people", bus.people_thing_in, "Q");
    finishRun("E");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
